// File: rtl/seg_scan_if.sv
// Frame-load and display-drive signals between a frame producer and seg_scan_ctrl.
// The master side loads frames and observes the display; the slave side is the scan controller.
interface seg_scan_if;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [3:0]  bcd;
    logic        dp_on;
    logic        upd_pending;
    logic        frame_tick;

    modport master (
        output load, value, dp_mask,
        input  an, bcd, dp_on, upd_pending, frame_tick
    );

    modport slave (
        input  load, value, dp_mask,
        output an, bcd, dp_on, upd_pending, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller: blanking gap per slot, tear-free frame loads.
// Optional LEAD_ZERO_BLANK_EN suppresses leading zero digits (digit0 always shown).
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  io_bus
);
    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYCLES);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [0:0]       r_state;
    logic [19:0]      r_act;
    logic [19:0]      r_pend;
    logic             r_upd;
    logic             r_seen;
    logic [3:0]       r_an;
    logic [3:0]       r_bcd;
    logic             r_dp;
    logic             r_tick;

    logic             w_wrap;
    logic             w_boundary;
    logic             w_commit;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_idx_nxt;
    logic [0:0]       w_state_nxt;
    logic [19:0]      w_new_frame;
    logic [19:0]      w_act_nxt;
    logic [3:0]       w_digit;
    logic [3:0]       w_dp_all;
    logic [3:0]       w_sup;
    logic             w_show;

`ifdef LEAD_ZERO_BLANK_EN
    // A digit is significant if it is 1..9 or has its point lit; everything above the top one goes dark.
    function automatic logic [3:0] lead_mask(input logic [19:0] f);
        logic sig;
        lead_mask = 4'b0000;
        sig       = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            sig = sig | f[16+i] | ((f[4*i +: 4] != 4'd0) && (f[4*i +: 4] <= 4'd9));
            lead_mask[i] = ~sig;
        end
    endfunction
    assign w_sup = lead_mask(w_act_nxt);
`else
    assign w_sup = 4'b0000;
`endif

    assign w_wrap      = (r_cnt == CNT_LAST);
    assign w_boundary  = w_wrap && (r_idx == 2'd3);
    assign w_commit    = w_boundary && (r_upd || io_bus.load || !r_seen);
    assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt   = w_wrap ? r_idx + 2'd1 : r_idx;
    assign w_new_frame = io_bus.load ? {io_bus.dp_mask, io_bus.value} : r_pend;
    // Outputs are computed from next-cycle state so a bypassed load is visible in the very first slot.
    assign w_act_nxt   = w_commit ? w_new_frame : r_act;
    assign w_dp_all    = w_act_nxt[19:16];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BLANK: if (w_cnt_nxt >= BLANK_C) w_state_nxt = ST_DRIVE;
            default:  if (w_wrap && (BLANK_CYCLES != 0)) w_state_nxt = ST_BLANK;
        endcase
    end

    always_comb begin
        w_digit = 4'd0;
        case (w_idx_nxt)
            2'd0:    w_digit = w_act_nxt[3:0];
            2'd1:    w_digit = w_act_nxt[7:4];
            2'd2:    w_digit = w_act_nxt[11:8];
            default: w_digit = w_act_nxt[15:12];
        endcase
    end

    assign w_show = (w_state_nxt == ST_DRIVE) && (w_digit <= 4'd9) && !w_sup[w_idx_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_state <= ST_BLANK;
            r_act   <= 20'd0;
            r_pend  <= 20'd0;
            r_upd   <= 1'b0;
            r_seen  <= 1'b0;
            r_an    <= 4'b1111;
            r_bcd   <= 4'd0;
            r_dp    <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_state <= w_state_nxt;
            r_act   <= w_act_nxt;
            r_tick  <= w_commit;
            r_an    <= w_show ? ~(4'b0001 << w_idx_nxt) : 4'b1111;
            r_bcd   <= w_show ? w_digit : 4'd0;
            r_dp    <= w_show & w_dp_all[w_idx_nxt];
            if (w_boundary) begin
                r_upd  <= 1'b0;
                r_seen <= 1'b1;
            end else if (io_bus.load) begin
                r_pend <= {io_bus.dp_mask, io_bus.value};
                r_upd  <= 1'b1;
            end
        end
    end

    assign io_bus.an          = r_an;
    assign io_bus.bcd         = r_bcd;
    assign io_bus.dp_on       = r_dp;
    assign io_bus.upd_pending = r_upd;
    assign io_bus.frame_tick  = r_tick;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with REFRESH_DIV=8, BLANK_CYCLES=2 (32-cycle frame).
module tb_seg_scan_ctrl;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [19:0] sb_q[$];

    seg_scan_if bus();

    seg_scan_ctrl #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {an, bcd, dp_on} at cycle k of a frame whose first (tick) cycle is k=0.
    function automatic logic [8:0] exp_out(input logic [19:0] f, input int k);
        int s;
        int c;
        logic [3:0] d;
        logic [3:0] sup;
        logic sig;
        s   = k / DIV;
        c   = k % DIV;
        d   = f[4*s +: 4];
        sup = 4'b0000;
        sig = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            if (f[16+i] || (f[4*i +: 4] >= 4'd1 && f[4*i +: 4] <= 4'd9)) sig = 1'b1;
            sup[i] = !sig;
        end
`endif
        if (c < BLANK || d > 4'd9 || sup[s]) return {4'b1111, 4'd0, 1'b0};
        return {~(4'b0001 << s), d, f[16+s]};
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] m);
        bus.load    = 1'b1;
        bus.value   = v;
        bus.dp_mask = m;
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    // Pops the expected frame and checks all 32 cycles; ends on the next boundary cycle.
    task automatic check_frame();
        logic [19:0] f;
        logic [8:0]  e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: no expected frame queued");
            return;
        end
        f = sb_q.pop_front();
        for (int k = 0; k < FRAME; k++) begin
            e = exp_out(f, k);
            checks++;
            if ({bus.an, bus.bcd, bus.dp_on} !== e) begin
                errors++;
                $display("FAIL scan frame=%h k=%0d: an=%b bcd=%h dp=%b, required an=%b bcd=%h dp=%b",
                         f, k, bus.an, bus.bcd, bus.dp_on, e[8:5], e[4:1], e[0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tick(input logic exp_pend);
        int n;
        n = 0;
        while (bus.frame_tick !== 1'b1 && n < 2 * FRAME) begin
            if (exp_pend) begin
                checks++;
                if (bus.upd_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL pend_hold: upd_pending=%b, required 1", bus.upd_pending);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout: frame_tick=%b, required 1 within %0d cycles", bus.frame_tick, 2 * FRAME);
        end
        checks++;
        if (bus.upd_pending !== 1'b0) begin
            errors++;
            $display("FAIL pend_clear: upd_pending=%b at tick, required 0", bus.upd_pending);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({bus.an, bus.bcd, bus.dp_on, bus.upd_pending, bus.frame_tick} !== {4'b1111, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL %s: an=%b bcd=%h dp=%b pend=%b tick=%b, required 1111/0/0/0/0",
                     tag, bus.an, bus.bcd, bus.dp_on, bus.upd_pending, bus.frame_tick);
        end
    endtask

    // After release: frame 0 is shown, the first boundary ticks, and frame 0 stays.
    task automatic scan_after_release();
        sb_q.push_back(20'd0);
        check_frame();
        checks++;
        if (bus.frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: frame_tick=%b, required 1", bus.frame_tick);
        end
        sb_q.push_back(20'd0);
        check_frame();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        check_reset_values("reset_hold");
        rst_n = 1'b1;
        scan_after_release();
    endtask

    task automatic test_load();
        step(5);
        sb_q.push_back({4'b0100, 16'h1234});
        drive_load(16'h1234, 4'b0100);
        wait_tick(1'b1);
        check_frame();
    endtask

    task automatic test_overwrite();
        step(3);
        sb_q.push_back({4'b0000, 16'h1111});
        drive_load(16'h1111, 4'b0000);
        step(4);
        sb_q[$] = {4'b0000, 16'h9876};
        drive_load(16'h9876, 4'b0000);
        wait_tick(1'b1);
        check_frame();
        checks++;
        if (bus.frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL extra_tick: frame_tick=%b, required 0", bus.frame_tick);
        end
    endtask

    task automatic test_boundary_load();
        step(FRAME - 1);
        sb_q.push_back({4'b0000, 16'h5555});
        drive_load(16'h5555, 4'b0000);
        checks++;
        if (bus.frame_tick !== 1'b1 || bus.upd_pending !== 1'b0) begin
            errors++;
            $display("FAIL bypass_tick: tick=%b pend=%b, required tick=1 pend=0", bus.frame_tick, bus.upd_pending);
        end
        check_frame();
    endtask

    task automatic test_reset_mid();
        step(2);
        drive_load(16'h4321, 4'b1111);
        checks++;
        if (bus.upd_pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_pend: upd_pending=%b, required 1", bus.upd_pending);
        end
        step(17);
        checks++;
        if (bus.an !== 4'b1011 || bus.bcd !== 4'h5) begin
            errors++;
            $display("FAIL mid_drive: an=%b bcd=%h, required an=1011 bcd=5", bus.an, bus.bcd);
        end
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_async");
        step(2);
        rst_n = 1'b1;
        scan_after_release();
    endtask

    task automatic test_invalid_digit();
        step(3);
        sb_q.push_back({4'b0000, 16'h0A07});
        drive_load(16'h0A07, 4'b0000);
        wait_tick(1'b1);
        check_frame();
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        bus.load    = 1'b0;
        bus.value   = 16'h0000;
        bus.dp_mask = 4'b0000;
        @(negedge clk);
        test_reset();
        test_load();
        test_overwrite();
        test_boundary_load();
        test_reset_mid();
        test_invalid_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
